// File: rtl/camera_frame_writer.sv
// camera_frame_writer: decimates an RGB565 pixel stream, converts kept pixels to RGB444 and
// writes them into a double-buffered frame BRAM. The buffer select flips only after a complete
// frame of exactly SRC_WIDTH*SRC_HEIGHT pixels, so the reader never sees a torn frame.
module camera_frame_writer #(
  parameter int unsigned SRC_WIDTH  = 320,
  parameter int unsigned SRC_HEIGHT = 240,
  parameter int unsigned DECIM      = 2,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk_65mhz,
  input  logic                  rst_n_in,
  input  logic [15:0]           pixel_in,
  input  logic                  pixel_valid_in,
  input  logic                  frame_done_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [11:0]           wr_data_out,
  output logic                  wr_buf_out,
  output logic                  frame_ready_out,
  output logic                  frame_error_out,
  output logic [7:0]            frame_count_out
);

  localparam int unsigned XW = (SRC_WIDTH > 1) ? $clog2(SRC_WIDTH) : 1;
  localparam int unsigned YW = $clog2(SRC_HEIGHT + 1);

  // DECIM is a power of two, so modulo reduces to a mask of the low bits.
  localparam logic [XW-1:0] XMask = XW'(DECIM - 1);
  localparam logic [YW-1:0] YMask = YW'(DECIM - 1);
  localparam logic [XW-1:0] XLast = XW'(SRC_WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(SRC_HEIGHT - 1);

  typedef enum logic [1:0] {StSync, StActive, StOverrun} state_e;

  state_e                state_q;
  logic [XW-1:0]         sx_q;
  logic [YW-1:0]         sy_q;
  logic [ADDR_WIDTH-1:0] wa_q;
  logic                  done_q;  // all pixels of the frame have been received
  logic                  buf_q;   // buffer currently being filled

  logic accept;
  logic keep;
  logic last_pix;
  logic complete;
  logic commit;
  logic buf_next;
  logic [11:0] pix_444;

  // Low bits of each colour channel are dropped by the RGB565 -> RGB444 conversion.
  logic unused_pix;
  assign unused_pix = ^{pixel_in[11], pixel_in[6:5], pixel_in[0]};

  // Pixel acceptance, decimation and frame completeness decode.
  always_comb begin
    accept   = (state_q == StActive) && pixel_valid_in && !done_q;
    keep     = accept && ((sx_q & XMask) == '0) && ((sy_q & YMask) == '0);
    last_pix = (sx_q == XLast) && (sy_q == YLast);
    // A pixel coinciding with frame_done counts toward the ending frame.
    complete = (state_q == StActive) &&
               (done_q ? !pixel_valid_in : (pixel_valid_in && last_pix));
    commit   = frame_done_in && complete;
    buf_next = buf_q ^ commit;
    pix_444  = {pixel_in[15:12], pixel_in[10:7], pixel_in[4:1]};
  end

  // Frame FSM, position counters and registered write/status outputs.
  always_ff @(posedge clk_65mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= StSync;
      sx_q            <= '0;
      sy_q            <= '0;
      wa_q            <= '0;
      done_q          <= 1'b0;
      buf_q           <= 1'b0;
      wr_en_out       <= 1'b0;
      wr_addr_out     <= '0;
      wr_data_out     <= '0;
      wr_buf_out      <= 1'b0;
      frame_ready_out <= 1'b0;
      frame_error_out <= 1'b0;
      frame_count_out <= '0;
    end else begin
      wr_en_out       <= keep;
      frame_ready_out <= 1'b0;
      frame_error_out <= 1'b0;
      if (keep) begin
        wr_addr_out <= wa_q;
        wr_data_out <= pix_444;
      end
      // A write carries the buffer in effect at acceptance, even if the frame commits now.
      wr_buf_out <= keep ? buf_q : buf_next;
      buf_q      <= buf_next;

      unique case (state_q)
        StSync: begin
          if (frame_done_in) begin
            sx_q    <= '0;
            sy_q    <= '0;
            wa_q    <= '0;
            done_q  <= 1'b0;
            state_q <= StActive;
          end
        end
        StActive: begin
          if (accept) begin
            if (keep) begin
              wa_q <= wa_q + ADDR_WIDTH'(1);
            end
            if (sx_q == XLast) begin
              sx_q <= '0;
              sy_q <= sy_q + YW'(1);
              if (last_pix) begin
                done_q <= 1'b1;
              end
            end else begin
              sx_q <= sx_q + XW'(1);
            end
          end else if (pixel_valid_in) begin
            // Pixel beyond a full frame.
            state_q <= StOverrun;
          end
        end
        StOverrun: begin
        end
        default: state_q <= StSync;
      endcase

      // End of frame overrides the counter updates above.
      if (frame_done_in && (state_q != StSync)) begin
        if (commit) begin
          frame_ready_out <= 1'b1;
          frame_count_out <= frame_count_out + 8'd1;
        end else begin
          frame_error_out <= 1'b1;
        end
        sx_q    <= '0;
        sy_q    <= '0;
        wa_q    <= '0;
        done_q  <= 1'b0;
        state_q <= StActive;
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Bench for camera_frame_writer on a small 8x4 frame with DECIM=2.
module tb_camera_frame_writer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int D  = 2;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   pixel = '0;
  logic          pv = 1'b0;
  logic          fd = 1'b0;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [11:0]   wr_data_out;
  logic          wr_buf_out;
  logic          frame_ready_out;
  logic          frame_error_out;
  logic [7:0]    frame_count_out;

  camera_frame_writer #(
    .SRC_WIDTH (W),
    .SRC_HEIGHT(H),
    .DECIM     (D),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_65mhz      (clk),
    .rst_n_in       (rst_n),
    .pixel_in       (pixel),
    .pixel_valid_in (pv),
    .frame_done_in  (fd),
    .wr_en_out      (wr_en_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .wr_buf_out     (wr_buf_out),
    .frame_ready_out(frame_ready_out),
    .frame_error_out(frame_error_out),
    .frame_count_out(frame_count_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   data;
    logic          bsel;
  } wr_t;

  typedef struct packed {
    logic [15:0] pix;
    logic [11:0] exp_data;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[8];

  int tests = 0;
  int fails = 0;

  // Reference model, tracked as a pixel index within the frame.
  bit m_sync;
  int m_n;
  bit m_buf;
  int m_count;
  bit exp_ready, exp_error, exp_bufout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_sync  = 1'b0;
    m_n     = 0;
    m_buf   = 1'b0;
    m_count = 0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wr_en"},   32'(wr_en_out), 0);
    check({tag, " addr"},    32'(wr_addr_out), 0);
    check({tag, " data"},    32'(wr_data_out), 0);
    check({tag, " buf"},     32'(wr_buf_out), 0);
    check({tag, " ready"},   32'(frame_ready_out), 0);
    check({tag, " error"},   32'(frame_error_out), 0);
    check({tag, " count"},   32'(frame_count_out), 0);
  endtask

  // One clock cycle: drive inputs, update model, then compare outputs at the next negedge.
  task automatic cycle(input bit v, input logic [15:0] p, input logic [11:0] expd, input bit f);
    bit  wrote;
    bit  old_buf;
    int  row, col;
    wr_t e;
    wrote   = 1'b0;
    old_buf = m_buf;
    exp_ready = 1'b0;
    exp_error = 1'b0;
    pixel = p;
    pv    = v;
    fd    = f;
    if (!m_sync) begin
      if (f) begin
        m_sync = 1'b1;
        m_n    = 0;
      end
    end else begin
      if (v) begin
        if (m_n < W * H) begin
          row = m_n / W;
          col = m_n % W;
          if ((row % D == 0) && (col % D == 0)) begin
            e.addr = AW'((row / D) * (W / D) + col / D);
            e.data = expd;
            e.bsel = m_buf;
            exp_q.push_back(e);
            wrote = 1'b1;
          end
        end
        if (m_n <= W * H) m_n++;
      end
      if (f) begin
        if (m_n == W * H) begin
          exp_ready = 1'b1;
          m_buf     = ~m_buf;
          m_count   = (m_count + 1) % 256;
        end else begin
          exp_error = 1'b1;
        end
        m_n = 0;
      end
    end
    exp_bufout = wrote ? old_buf : m_buf;
    @(posedge clk);
    @(negedge clk);
    pv = 1'b0;
    fd = 1'b0;
    if (wr_en_out) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 wr_addr_out, wr_data_out);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr_out), 32'(e.addr));
        check("wr_data", 32'(wr_data_out), 32'(e.data));
        check("wr_buf_of_write", 32'(wr_buf_out), 32'(e.bsel));
      end
    end else begin
      check("wr_buf", 32'(wr_buf_out), 32'(exp_bufout));
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL missing_write: got no write, expected addr %0h", exp_q[0].addr);
      exp_q.delete();
    end
    check("frame_ready", 32'(frame_ready_out), 32'(exp_ready));
    check("frame_error", 32'(frame_error_out), 32'(exp_error));
    check("frame_count", 32'(frame_count_out), 32'(m_count));
  endtask

  task automatic pixels(input int n, input logic [15:0] p, input logic [11:0] expd);
    for (int i = 0; i < n; i++) cycle(1'b1, p, expd, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 12'h0, 1'b0);
  endtask

  task automatic done_pulse();
    cycle(1'b0, 16'h0, 12'h0, 1'b1);
  endtask

  initial begin
    int k;
    tbl[0] = '{pix: 16'hF800, exp_data: 12'hF00};
    tbl[1] = '{pix: 16'h07E0, exp_data: 12'h0F0};
    tbl[2] = '{pix: 16'h001F, exp_data: 12'h00F};
    tbl[3] = '{pix: 16'h8410, exp_data: 12'h888};
    tbl[4] = '{pix: 16'hFFFF, exp_data: 12'hFFF};
    tbl[5] = '{pix: 16'h0000, exp_data: 12'h000};
    tbl[6] = '{pix: 16'h1234, exp_data: 12'h14A};
    tbl[7] = '{pix: 16'hA5A5, exp_data: 12'hAB2};

    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Unsynchronised pixels are ignored.
    pixels(10, 16'hFFFF, 12'hFFF);
    check("sync addr", 32'(wr_addr_out), 0);
    check("sync data", 32'(wr_data_out), 0);

    // Nominal frame into buffer 0.
    done_pulse();
    pixels(W * H, 16'hFFFF, 12'hFFF);
    idle(1);
    done_pulse();
    idle(1);

    // Colour conversion table, applied to the kept positions of a frame into buffer 1.
    k = 0;
    for (int i = 0; i < W * H; i++) begin
      if (((i / W) % D == 0) && ((i % W) % D == 0)) begin
        cycle(1'b1, tbl[k].pix, tbl[k].exp_data, 1'b0);
        k++;
      end else begin
        cycle(1'b1, 16'h5555, 12'h0, 1'b0);
      end
    end
    done_pulse();

    // Short frame, then a full frame rewriting the same buffer.
    pixels(20, 16'h1234, 12'h14A);
    done_pulse();
    pixels(W * H, 16'hA5A5, 12'hAB2);
    done_pulse();

    // Overrun: extra pixels are dropped and the frame is rejected.
    pixels(40, 16'hF800, 12'hF00);
    done_pulse();

    // Last pixel coincides with frame_done.
    pixels(W * H - 1, 16'h07E0, 12'h0F0);
    cycle(1'b1, 16'h07E0, 12'h0F0, 1'b1);
    idle(2);

    // Back-to-back frame_done pulses: each sees an empty frame.
    done_pulse();
    done_pulse();

    // Overrun where the extra pixel arrives together with frame_done.
    pixels(W * H, 16'hFFFF, 12'hFFF);
    cycle(1'b1, 16'hFFFF, 12'hFFF, 1'b1);
    idle(1);

    // Mid-frame reset.
    pixels(13, 16'hFFFF, 12'hFFF);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pixels(10, 16'hFFFF, 12'hFFF);
    done_pulse();
    pixels(W * H, 16'h8410, 12'h888);
    done_pulse();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
